tune_player: RTL and testbench

Downstream consumer of the blinker's slow square-wave `blink` output, used here as a beat clock. On every rising edge of the beat, it steps through a fixed 8-entry note table and drives a square-wave audio output at the selected pitch. Table entry 7 is a rest. The block sits between the blinker and the speaker/PWM pin; all logic runs on the single system clock (50 MHz).

---
 rtl/tune_if.sv | 24 ++
 rtl/tune_player.sv | 112 +++++++++++
 tb/tb_tune_player.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/tune_if.sv
// Beat/enable controls in, audio tone and play status out.
interface tune_if;
  logic       beat;
  logic       enable;
  logic       tone;
  logic [2:0] note_idx;
  logic       playing;

  modport master (
    output beat,
    output enable,
    input  tone,
    input  note_idx,
    input  playing
  );

  modport slave (
    input  beat,
    input  enable,
    output tone,
    output note_idx,
    output playing
  );
endinterface

// File: rtl/tune_player.sv
// Steps through an 8-note table on each rising edge of a slow beat and
// drives a square-wave tone at the selected pitch. Entry 7 is a rest.
module tune_player #(
  parameter int DIV_SHIFT = 0
) (
  input  logic clk,
  input  logic rst,
  tune_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] REST = 2'd2;

  // Half-period of each note in clk cycles; zero marks the rest.
  localparam logic [15:0] NOTE_TABLE [8] = '{
    16'd47778, 16'd42566, 16'd37922, 16'd35793,
    16'd31888, 16'd28409, 16'd25310, 16'd0
  };

  logic [15:0] half_tab [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_half
    assign half_tab[gi] = NOTE_TABLE[gi] >> DIV_SHIFT;
  end

  logic [1:0]  state_reg;
  logic [2:0]  note_idx_reg;
  logic        tone_reg;
  logic        playing_reg;
  logic [15:0] div_reg;
  logic        b1_reg;
  logic        b2_reg;

  logic        rise;
  logic [2:0]  next_idx;
  logic [15:0] cur_h;
  logic [15:0] next_h;

  assign rise     = b1_reg & ~b2_reg;
  assign next_idx = note_idx_reg + 3'd1;
  assign cur_h    = half_tab[note_idx_reg];
  assign next_h   = half_tab[next_idx];

  // Beat edge detector; keeps sampling in every state so re-enable sees no stale edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b1_reg <= 1'b0;
      b2_reg <= 1'b0;
    end else begin
      b1_reg <= bus.beat;
      b2_reg <= b1_reg;
    end
  end

  // Play/rest/idle sequencing with the tone divider; a low enable overrides a beat edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      note_idx_reg <= 3'd0;
      tone_reg     <= 1'b0;
      playing_reg  <= 1'b0;
      div_reg      <= 16'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          tone_reg <= 1'b0;
          if (bus.enable) begin
            state_reg   <= (cur_h == 16'd0) ? REST : PLAY;
            div_reg     <= cur_h - 16'd1;
            playing_reg <= 1'b1;
          end else begin
            playing_reg <= 1'b0;
          end
        end
        PLAY, REST: begin
          if (!bus.enable) begin
            state_reg   <= IDLE;
            tone_reg    <= 1'b0;
            playing_reg <= 1'b0;
          end else if (rise) begin
            // New note always starts from a clean low phase and a full half-period.
            note_idx_reg <= next_idx;
            div_reg      <= next_h - 16'd1;
            tone_reg     <= 1'b0;
            state_reg    <= (next_h == 16'd0) ? REST : PLAY;
          end else if (state_reg == PLAY) begin
            if (div_reg == 16'd0) begin
              tone_reg <= ~tone_reg;
              div_reg  <= cur_h - 16'd1;
            end else begin
              div_reg <= div_reg - 16'd1;
            end
          end else begin
            // Rest: tone silent, divider frozen.
            tone_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          tone_reg    <= 1'b0;
          playing_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tone     = tone_reg;
  assign bus.note_idx = note_idx_reg;
  assign bus.playing  = playing_reg;

endmodule

// File: tb/tb_tune_player.sv
// Scoreboard bench for tune_player: every change of {playing, note_idx, tone}
// is matched, in order and at its exact cycle, against a queue of expected events.
module tb_tune_player;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  tune_if bus ();

  tune_player #(.DIV_SHIFT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic       p;
    logic [2:0] idx;
    logic       tn;
  } ev_t;

  ev_t exp_q[$];

  // Half-periods with DIV_SHIFT = 8, worked out by hand (table >> 8).
  int h_tab [8] = '{186, 166, 148, 139, 124, 110, 98, 0};

  logic mon_en    = 1'b0;
  logic done      = 1'b0;
  logic init_done = 1'b0;
  logic [4:0] prev = 5'd0;
  logic [4:0] cur;
  ev_t  e;
  int   checks   = 0;
  int   failures = 0;

  task automatic expect_ev(input int t, input logic p, input logic [2:0] idx, input logic tn);
    ev_t x;
    x.t = t; x.p = p; x.idx = idx; x.tn = tn;
    exp_q.push_back(x);
  endtask

  // Note start at edge s (tone low), then a toggle every H edges until s+len.
  task automatic expect_note(input int s, input int idx, input int len);
    logic tn;
    tn = 1'b0;
    expect_ev(s, 1'b1, idx[2:0], 1'b0);
    if (h_tab[idx] != 0) begin
      for (int t = s + h_tab[idx]; t < s + len; t += h_tab[idx]) begin
        tn = ~tn;
        expect_ev(t, 1'b1, idx[2:0], tn);
      end
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Beat high for 'width' cycles such that the index advances at edge e.
  task automatic pulse_for_edge(input int e_edge, input int width);
    wait_until(e_edge - 2);
    bus.beat = 1'b1;
    repeat (width) @(negedge clk);
    bus.beat = 1'b0;
  endtask

  // Stimulus
  initial begin
    int s;
    int ns;
    bus.beat   = 1'b0;
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);

    // Start on note 0, then 11 beats: 1..7, 0 (wrap), 1, 2, 3
    s = cyc + 1;
    expect_note(s, 0, 500);
    bus.enable = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      ns = s + ((k == 1) ? 500 : 400);
      expect_note(ns, k % 8, (k == 11) ? 300 : 400);
      pulse_for_edge(ns, 1);
      s = ns;
    end

    // Enable falls on the same edge the rise is seen, at index 3
    expect_ev(s + 300, 1'b0, 3'd3, 1'b0);
    wait_until(s + 298);
    bus.beat = 1'b1;
    @(negedge clk);
    bus.enable = 1'b0;
    bus.beat   = 1'b0;
    repeat (20) @(negedge clk);

    // Re-enable resumes index 3
    s = cyc + 1;
    expect_note(s, 3, 300);
    bus.enable = 1'b1;

    // Beat held high for 1000 cycles, then a single-cycle pulse
    ns = s + 300;
    expect_note(ns, 4, 1100);
    pulse_for_edge(ns, 1000);
    s  = ns;
    ns = s + 1100;
    expect_note(ns, 5, 300);
    pulse_for_edge(ns, 1);
    s = ns;

    // Stop
    expect_ev(s + 300, 1'b0, 3'd5, 1'b0);
    wait_until(s + 299);
    bus.enable = 1'b0;

    // Beat rises while idle, then enable: no advance
    repeat (10) @(negedge clk);
    bus.beat = 1'b1;
    repeat (5) @(negedge clk);
    s = cyc + 1;
    expect_note(s, 5, 250);
    bus.enable = 1'b1;
    repeat (20) @(negedge clk);
    bus.beat = 1'b0;
    expect_ev(s + 250, 1'b0, 3'd5, 1'b0);
    wait_until(s + 249);
    bus.enable = 1'b0;

    // Asynchronous reset while tone is high
    repeat (10) @(negedge clk);
    s = cyc + 1;
    expect_note(s, 5, 150);
    expect_ev(s + 150, 1'b0, 3'd0, 1'b0);
    bus.enable = 1'b1;
    wait_until(s + 150);
    #2;
    rst        = 1'b0;
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    done = 1'b1;
  end

  // Monitor: samples shortly after each falling clock edge and on reset assertion
  always begin
    @(negedge clk or negedge rst);
    #1;
    if (mon_en) begin
      cur = {bus.playing, bus.note_idx, bus.tone};
      if (!init_done) begin
        checks++;
        if (cur !== 5'd0) begin
          failures++;
          $display("FAIL reset_state: got playing/idx/tone=%b, want 00000", cur);
        end else begin
          $display("reset_state cyc=%0d outputs=%b ok", cyc, cur);
        end
        prev      = cur;
        init_done = 1'b1;
      end else if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: cyc=%0d playing=%0b idx=%0d tone=%0b, want no change",
                   cyc, cur[4], cur[3:1], cur[0]);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.t || cur !== {e.p, e.idx, e.tn}) begin
            failures++;
            $display("FAIL event: got cyc=%0d playing=%0b idx=%0d tone=%0b, want cyc=%0d playing=%0b idx=%0d tone=%0b",
                     cyc, cur[4], cur[3:1], cur[0], e.t, e.p, e.idx, e.tn);
          end else begin
            $display("event cyc=%0d playing=%0b idx=%0d tone=%0b ok", cyc, cur[4], cur[3:1], cur[0]);
          end
        end
        prev = cur;
      end
      if (done) begin
        checks++;
        if (exp_q.size() != 0) begin
          failures++;
          $display("FAIL missing_events: got %0d expected events never seen, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  // Bound on total run time
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
